// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, default bit-rate divisors, line-control
// field positions and data-length decode. Shared by the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Clocks per bit at 18.432 MHz
  localparam int unsigned DIV_2400_DEF  = 7680;
  localparam int unsigned DIV_4800_DEF  = 3840;
  localparam int unsigned DIV_9600_DEF  = 1920;
  localparam int unsigned DIV_19200_DEF = 960;

  localparam int LCR_LEN_LO  = 0;
  localparam int LCR_LEN_HI  = 1;
  localparam int LCR_STOP    = 2;
  localparam int LCR_PAR_DIS = 3;
  localparam int LCR_PAR_ODD = 4;

  function automatic logic [3:0] data_len(input logic [1:0] len_sel);
    return 4'd8 - {2'b00, len_sel};
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] len_sel);
    return 8'hFF >> len_sel;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: selects the divisor for the latched rate and emits a
// one-cycle bit_tick every DIV cycles while not held in clear.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_2400  = DIV_2400_DEF,
  parameter int unsigned DIV_4800  = DIV_4800_DEF,
  parameter int unsigned DIV_9600  = DIV_9600_DEF,
  parameter int unsigned DIV_19200 = DIV_19200_DEF
) (
  input  logic       clk_tx,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic       clear,
  output logic       bit_tick
);

  logic [12:0] cnt_q, cnt_d;
  logic [12:0] div_m1;

  always_comb begin
    case (baud_sel)
      2'b00:   div_m1 = 13'(DIV_2400 - 1);
      2'b01:   div_m1 = 13'(DIV_4800 - 1);
      2'b10:   div_m1 = 13'(DIV_9600 - 1);
      default: div_m1 = 13'(DIV_19200 - 1);
    endcase
  end

  assign bit_tick = !clear && (cnt_q == div_m1);

  always_comb begin
    cnt_d = cnt_q + 13'd1;
    if (clear || bit_tick) cnt_d = '0;
  end

  always_ff @(posedge clk_tx) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit half: byte handshake in, LSB-first frame out with configurable
// length/parity/stop. Optional line break via macro UART_TX_BREAK_EN.
//
// state  | meaning
// IDLE   | line high, ready for a frame (or holding a break when enabled)
// START  | start bit (line 0) for one bit period
// DATA   | N data bits, LSB first
// PARITY | parity bit, only when parity is enabled
// STOP   | 1 or 2 stop bits; also the recovery period after a break
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned DIV_2400  = DIV_2400_DEF,
  parameter int unsigned DIV_4800  = DIV_4800_DEF,
  parameter int unsigned DIV_9600  = DIV_9600_DEF,
  parameter int unsigned DIV_19200 = DIV_19200_DEF
) (
  input  logic       clk_tx,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic [4:0] line_control_reg,
  input  logic [7:0] data_tx,
  input  logic       tx_start,
`ifdef UART_TX_BREAK_EN
  input  logic       tx_break,
`endif
  output logic       tx_ready,
  output logic       serial_data_tx,
  output logic       active_flag_tx,
  output logic       transmission_done_flag
);

  uart_state_e state_q, state_d;
  logic [1:0]  baud_q, baud_d;
  logic [3:0]  lcr_q, lcr_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
`ifdef UART_TX_BREAK_EN
  logic        brk_q, brk_d;
`endif

  logic bit_tick;
  logic last_bit;

  uart_baud_gen #(
    .DIV_2400 (DIV_2400),
    .DIV_4800 (DIV_4800),
    .DIV_9600 (DIV_9600),
    .DIV_19200(DIV_19200)
  ) u_baud_gen (
    .clk_tx  (clk_tx),
    .rst     (rst),
    .baud_sel(baud_q),
    .clear   (state_q == IDLE),
    .bit_tick(bit_tick)
  );

  assign last_bit = ({1'b0, bit_idx_q} == (data_len(lcr_q[LCR_LEN_HI:LCR_LEN_LO]) - 4'd1));

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    lcr_d      = lcr_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    active_d   = active_q;
    done_d     = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_d      = brk_q;
`endif

    case (state_q)
      IDLE: begin
        if (tx_start && ready_q) begin
          baud_d     = baud_sel;
          lcr_d      = line_control_reg[3:0];
          shift_d    = data_tx;
          // Parity is fixed at acceptance; only the N transmitted bits count
          par_d      = (^(data_tx & data_mask(line_control_reg[LCR_LEN_HI:LCR_LEN_LO])))
                       ^ line_control_reg[LCR_PAR_ODD];
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          state_d    = START;
          tx_d       = 1'b0;
          ready_d    = 1'b0;
          active_d   = 1'b1;
        end
`ifdef UART_TX_BREAK_EN
        else if (tx_break) begin
          brk_d   = 1'b1;
          baud_d  = baud_sel;
          tx_d    = 1'b0;
          ready_d = 1'b0;
        end else if (brk_q) begin
          // One single-stop period of idle line before ready returns
          brk_d      = 1'b0;
          lcr_d      = '0;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
          state_d    = STOP;
        end
`endif
      end

      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end

      DATA: begin
        if (bit_tick) begin
          if (last_bit) begin
            if (!lcr_q[LCR_PAR_DIS]) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end

      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        if (bit_tick) begin
          if (lcr_q[LCR_STOP] && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d  = IDLE;
            ready_d  = 1'b1;
            active_d = 1'b0;
            done_d   = active_q;  // break recovery ends without a done pulse
          end
        end
      end

      default: begin
        state_d  = IDLE;
        tx_d     = 1'b1;
        ready_d  = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_tx) begin
    if (!rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      lcr_q      <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      lcr_q      <= lcr_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      active_q   <= active_d;
      done_q     <= done_d;
`ifdef UART_TX_BREAK_EN
      brk_q      <= brk_d;
`endif
    end
  end

  assign tx_ready               = ready_q;
  assign serial_data_tx         = tx_q;
  assign active_flag_tx         = active_q;
  assign transmission_done_flag = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter: frame formats, rates,
// back-to-back handshake, mid-frame reset and (when UART_TX_BREAK_EN) break.
module tb_uart_transmitter;

  logic       clk_tx = 1'b0;
  logic       rst;
  logic [1:0] baud_sel;
  logic [4:0] line_control_reg;
  logic [7:0] data_tx;
  logic       tx_start;
`ifdef UART_TX_BREAK_EN
  logic       tx_break;
`endif
  logic       tx_ready;
  logic       serial_data_tx;
  logic       active_flag_tx;
  logic       transmission_done_flag;

  int n_checks = 0;
  int n_fail   = 0;

  uart_transmitter dut (
    .clk_tx                (clk_tx),
    .rst                   (rst),
    .baud_sel              (baud_sel),
    .line_control_reg      (line_control_reg),
    .data_tx               (data_tx),
    .tx_start              (tx_start),
`ifdef UART_TX_BREAK_EN
    .tx_break              (tx_break),
`endif
    .tx_ready              (tx_ready),
    .serial_data_tx        (serial_data_tx),
    .active_flag_tx        (active_flag_tx),
    .transmission_done_flag(transmission_done_flag)
  );

  always #5 clk_tx = ~clk_tx;

  // Observes one frame whose cycle 0 is the next negedge; cycle nbits*div is the
  // expected done cycle. bits[k] is the line at the start of bit period k.
  task automatic run_frame(input int nbits, input int div, input bit drop_start,
                           input int pulse_cyc, output logic [11:0] bits,
                           output bit stable, output bit flags_ok,
                           output int done_cyc, output int done_cnt);
    bits = '0; stable = 1'b1; flags_ok = 1'b1; done_cyc = -1; done_cnt = 0;
    for (int c = 0; c <= nbits * div; c++) begin
      @(negedge clk_tx);
      if (c == 0 && drop_start) tx_start = 1'b0;
      if (pulse_cyc >= 0 && c == pulse_cyc) begin
        tx_start         = 1'b1;
        data_tx          = ~data_tx;
        line_control_reg = ~line_control_reg;
        baud_sel         = ~baud_sel;
      end
      if (pulse_cyc >= 0 && c == pulse_cyc + 1) tx_start = 1'b0;
      if (transmission_done_flag === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c < nbits * div) begin
        if (c % div == 0) bits[c / div] = serial_data_tx;
        else if (serial_data_tx !== bits[c / div]) stable = 1'b0;
        if (active_flag_tx !== 1'b1 || tx_ready !== 1'b0) flags_ok = 1'b0;
      end else if (active_flag_tx !== 1'b0 || tx_ready !== 1'b1 || serial_data_tx !== 1'b1) begin
        flags_ok = 1'b0;
      end
    end
  endtask

  task automatic accept(input logic [1:0] b, input logic [4:0] l, input logic [7:0] d,
                        input bit hold);
    @(negedge clk_tx);
    baud_sel = b; line_control_reg = l; data_tx = d; tx_start = 1'b1;
    @(posedge clk_tx);
    #1;
    if (!hold) tx_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk_tx);
    n_checks++;
    if (serial_data_tx !== 1'b1) begin n_fail++; $display("FAIL reset_line got=%b exp=1", serial_data_tx); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
    n_checks++;
    if (active_flag_tx !== 1'b0) begin n_fail++; $display("FAIL reset_active got=%b exp=0", active_flag_tx); end
    n_checks++;
    if (transmission_done_flag !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", transmission_done_flag); end
    rst = 1'b1;
    repeat (2) @(negedge clk_tx);
  endtask

  // 9600, 8E1, 0x55: start 0, 1010_1010 LSB first, even parity 0, stop 1
  task automatic test_frame_even;
    logic [11:0] bits; bit stable, flags; int dcyc, dcnt;
    accept(2'b10, 5'b00000, 8'h55, 1'b0);
    run_frame(11, 1920, 1'b0, -1, bits, stable, flags, dcyc, dcnt);
    n_checks++;
    if (bits !== 12'h4AA) begin n_fail++; $display("FAIL even_bits got=%h exp=4aa", bits); end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL even_stable got=0 exp=1"); end
    n_checks++;
    if (dcyc != 21120 || dcnt != 1) begin n_fail++; $display("FAIL even_done got=%0d/%0d exp=21120/1", dcyc, dcnt); end
    n_checks++;
    if (!flags) begin n_fail++; $display("FAIL even_flags got=0 exp=1"); end
  endtask

  // 19200, 8O1, 0xA3: four ones so odd parity bit is 1
  task automatic test_frame_odd;
    logic [11:0] bits; bit stable, flags; int dcyc, dcnt;
    accept(2'b11, 5'b10000, 8'hA3, 1'b0);
    run_frame(11, 960, 1'b0, -1, bits, stable, flags, dcyc, dcnt);
    n_checks++;
    if (bits !== 12'h746) begin n_fail++; $display("FAIL odd_bits got=%h exp=746", bits); end
    n_checks++;
    if (!stable || !flags) begin n_fail++; $display("FAIL odd_timing got=%b%b exp=11", stable, flags); end
    n_checks++;
    if (dcyc != 10560 || dcnt != 1) begin n_fail++; $display("FAIL odd_done got=%0d/%0d exp=10560/1", dcyc, dcnt); end
  endtask

  // 9600, 7N2, 0xFF: seven ones, no parity, two stop bits, MSB not sent
  task automatic test_frame_7n2;
    logic [11:0] bits; bit stable, flags; int dcyc, dcnt;
    accept(2'b10, 5'b01101, 8'hFF, 1'b0);
    run_frame(10, 1920, 1'b0, -1, bits, stable, flags, dcyc, dcnt);
    n_checks++;
    if (bits !== 12'h3FE) begin n_fail++; $display("FAIL 7n2_bits got=%h exp=3fe", bits); end
    n_checks++;
    if (!stable || !flags) begin n_fail++; $display("FAIL 7n2_timing got=%b%b exp=11", stable, flags); end
    n_checks++;
    if (dcyc != 19200 || dcnt != 1) begin n_fail++; $display("FAIL 7n2_done got=%0d/%0d exp=19200/1", dcyc, dcnt); end
  endtask

  // 19200, 5N1, start held high: second frame starts the cycle after done
  task automatic test_back_to_back;
    logic [11:0] bits; bit stable, flags; int dcyc, dcnt, extra;
    accept(2'b11, 5'b01011, 8'h00, 1'b1);
    run_frame(7, 960, 1'b0, -1, bits, stable, flags, dcyc, dcnt);
    data_tx = 8'hFF;
    n_checks++;
    if (bits !== 12'h040 || !stable || dcyc != 6720) begin
      n_fail++; $display("FAIL b2b_first got=%h/%b/%0d exp=040/1/6720", bits, stable, dcyc);
    end
    run_frame(7, 960, 1'b1, 2000, bits, stable, flags, dcyc, dcnt);
    n_checks++;
    if (bits !== 12'h07E || !stable) begin n_fail++; $display("FAIL b2b_second got=%h/%b exp=07e/1", bits, stable); end
    n_checks++;
    if (dcyc != 6720 || dcnt != 1 || !flags) begin
      n_fail++; $display("FAIL b2b_second_done got=%0d/%0d/%b exp=6720/1/1", dcyc, dcnt, flags);
    end
    baud_sel = 2'b11; line_control_reg = 5'b01011; data_tx = 8'h00;
    extra = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_tx);
      if (serial_data_tx !== 1'b1 || tx_ready !== 1'b1 || transmission_done_flag !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL b2b_no_extra got=%0d exp=0", extra); end
  endtask

  // Reset during the 4th data bit, then a clean 5N1 frame of 0x3C
  task automatic test_mid_reset;
    logic [11:0] bits; bit stable, flags; int dcyc, dcnt, bad;
    accept(2'b11, 5'b00000, 8'hA5, 1'b0);
    repeat (4 * 960 + 100) @(negedge clk_tx);
    rst = 1'b0;
    @(negedge clk_tx);
    n_checks++;
    if (serial_data_tx !== 1'b1 || tx_ready !== 1'b1 || active_flag_tx !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state got=%b%b%b exp=110", serial_data_tx, tx_ready, active_flag_tx);
    end
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_tx);
      if (transmission_done_flag !== 1'b0 || serial_data_tx !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL midrst_quiet got=%0d exp=0", bad); end
    accept(2'b11, 5'b01011, 8'h3C, 1'b0);
    run_frame(7, 960, 1'b0, -1, bits, stable, flags, dcyc, dcnt);
    n_checks++;
    if (bits !== 12'h078 || !stable || !flags || dcyc != 6720 || dcnt != 1) begin
      n_fail++; $display("FAIL midrst_next got=%h/%b/%b/%0d/%0d exp=078/1/1/6720/1", bits, stable, flags, dcyc, dcnt);
    end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break;
    int low_cnt, rdy_low, line_bad;
    baud_sel = 2'b10;
    @(negedge clk_tx);
    tx_break = 1'b1;
    low_cnt = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk_tx);
      if (serial_data_tx === 1'b0 && tx_ready === 1'b0) low_cnt++;
    end
    tx_break = 1'b0;
    n_checks++;
    if (low_cnt != 5000) begin n_fail++; $display("FAIL break_low got=%0d exp=5000", low_cnt); end
    rdy_low = 0; line_bad = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk_tx);
      if (tx_ready === 1'b0) rdy_low++;
      if (serial_data_tx !== 1'b1 || transmission_done_flag !== 1'b0) line_bad++;
    end
    n_checks++;
    if (rdy_low != 1920) begin n_fail++; $display("FAIL break_recover got=%0d exp=1920", rdy_low); end
    n_checks++;
    if (line_bad != 0) begin n_fail++; $display("FAIL break_line got=%0d exp=0", line_bad); end
  endtask
`endif

  initial begin
    rst = 1'b0; baud_sel = 2'b00; line_control_reg = '0; data_tx = '0; tx_start = 1'b0;
`ifdef UART_TX_BREAK_EN
    tx_break = 1'b0;
`endif
    test_reset();
    test_frame_even();
    test_frame_odd();
    test_frame_7n2();
    test_back_to_back();
    test_mid_reset();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
